mem_io_bridge: RTL and testbench
================================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the TX FIFO depth; legal values are powers of two from 2 to 16.
REQ-002 Parameter IO_BANK, default 8'hFF, is the address bank that selects the I/O registers.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 core_addr  in  24  core address: [23:16] is the bank, [15:0] is the offset.
REQ-006 core_wdata  in  16  core write data.
REQ-007 core_we  in  1  core write enable; a write takes effect at the clock edge ending the cycle in which core_we is high.
REQ-008 core_rdata  out  16  read data returned to the core, combinational from core_addr in the same cycle.
REQ-009 ram_addr  out  16  RAM address, equal to core_addr[15:0].
REQ-010 ram_wdata  out  16  RAM write data, equal to core_wdata.
REQ-011 ram_we  out  1  RAM write enable, equal to core_we when bank 0 is selected, else 0.
REQ-012 ram_rdata  in  16  combinational RAM read data.
REQ-013 gpio_out  out  16  GPIO output register.
REQ-014 gpio_in  in  16  GPIO input pins, double-flop synchronised.
REQ-015 tx_data  out  8  FIFO head byte.
REQ-016 tx_valid  out  1  FIFO is not empty.
REQ-017 tx_ready  in  1  consumer accepts; a pop occurs on a clock edge where tx_valid and tx_ready are both high.

Function
REQ-018 Bank decode shall be as follows:
- bank 0: RAM pass-through; core_rdata = ram_rdata.
- bank IO_BANK: I/O registers.
- any other bank: reads return 16'h0000; writes are ignored; ram_we = 0.
REQ-019 The I/O offset map shall be:
- 0 GPIO_OUT: R/W.
- 1 GPIO_IN: R; returns the synchronised value.
- 2 TX_DATA: W; pushes core_wdata[7:0]; reads return 0.
- 3 STATUS: R/W1C.
- 4 TIMER_LO: R.
- 5 TIMER_HI: R.
- any other offset: reads return 0; writes are ignored.
REQ-020 STATUS bit assignment:
- bit0: FIFO full.
- bit1: FIFO empty.
- bits[6:2]: FIFO count.
- bit7: sticky overflow.
- all other bits: 0.
REQ-021 A write to STATUS with core_wdata[7]=1 shall clear the overflow flag; other written bits are ignored.
REQ-022 The timer shall be a 32-bit free-running counter that increments every cycle and wraps from FFFF_FFFF to 0.
REQ-023 TIMER_LO shall return the live timer[15:0].
REQ-024 On any clock edge with TIMER_LO addressed and core_we=0, timer[31:16] shall be captured into a snapshot register.
REQ-025 TIMER_HI shall return the snapshot register, not the live upper bits.
REQ-026 A TX_DATA write when the FIFO is full and no pop occurs in the same cycle shall be dropped and shall set the overflow flag.
REQ-027 A push and a pop in the same cycle when the FIFO is full shall both be accepted; count is unchanged.
REQ-028 A push and a pop in the same cycle when the FIFO is non-full and non-empty shall both be accepted; count is unchanged.
REQ-029 A pop when the FIFO is empty is impossible, because tx_valid is low; tx_ready is ignored.
REQ-030 A push to an empty FIFO shall make tx_valid high on the following cycle; there is no fall-through.
REQ-031 FIFO read and write pointers shall wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
REQ-032 tx_data shall be stable while tx_valid is high and no pop occurs.
REQ-033 GPIO_OUT shall update at the write edge.
REQ-034 When a set event and a W1C clear of the overflow flag occur in the same cycle, set shall win.

Reset
REQ-035 Asserting reset shall immediately force the following values:
- gpio_out = 0.
- timer = 0.
- snapshot = 0.
- overflow = 0.
- FIFO pointers and count = 0.
- tx_valid = 0.
- both GPIO sync flops = 0.
REQ-036 Reset asserted mid-transfer shall discard all FIFO contents; no pop is reported.
REQ-037 The combinational paths (core_rdata, ram_*) are not gated by reset.

Structure
REQ-038 A shared package shall hold:
- I/O offset constants.
- STATUS bit positions.
- default IO_BANK.
REQ-039 The FIFO shall be a single sub-module, tx_fifo, with push/pop/full/empty/count ports; the register block and decode stay in mem_io_bridge.

Verification
REQ-040 Scenario, RAM pass-through:
- stimulus: write 16'hBEEF at core_addr 24'h000010.
- response: ram_we=1 and ram_addr=16'h0010 for that cycle; a read of the same address returns ram_rdata.
REQ-041 Scenario, GPIO:
- stimulus: write 16'h00A5 to FF:0000; drive gpio_in=16'h1234.
- response: gpio_out=16'h00A5 next cycle; GPIO_IN reads 16'h1234 from the third edge onward.
REQ-042 Scenario, FIFO fill and overflow:
- stimulus: tx_ready=0; 9 writes of bytes 01..09 to FF:0002.
- response: STATUS reads 16'h00A1 (full, count 8, overflow); then tx_ready=1 drains 01..08 in order, with byte 09 absent.
REQ-043 Scenario, overflow clear:
- stimulus: write 16'h0080 to STATUS with the FIFO empty.
- response: STATUS reads 16'h0002.
REQ-044 Scenario, timer coherence:
- stimulus: force the timer to 32'h0000_FFFF; read TIMER_LO, then TIMER_HI on the next cycle.
- response: reads return 16'hFFFF then 16'h0000.
REQ-045 Scenario, reset with data queued:
- stimulus: assert reset with 3 bytes queued and tx_ready=0.
- response: tx_valid=0 without waiting for a clock edge; STATUS reads 16'h0002 after deassertion.

Source files
------------

// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: shared constants for the memory/I-O bridge.
//   - I/O register offsets within the I/O bank
//   - STATUS register bit positions
//   - default I/O bank number
//   - bank decode helper
package mem_io_bridge_pkg;

    localparam logic [7:0]  IO_BANK_DEFAULT = 8'hFF;

    localparam logic [15:0] OFF_GPIO_OUT = 16'h0000;
    localparam logic [15:0] OFF_GPIO_IN  = 16'h0001;
    localparam logic [15:0] OFF_TX_DATA  = 16'h0002;
    localparam logic [15:0] OFF_STATUS   = 16'h0003;
    localparam logic [15:0] OFF_TIMER_LO = 16'h0004;
    localparam logic [15:0] OFF_TIMER_HI = 16'h0005;

    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_COUNT_LSB = 2;
    localparam int unsigned ST_COUNT_MSB = 6;
    localparam int unsigned ST_OVERFLOW  = 7;
    localparam int unsigned ST_COUNT_W   = ST_COUNT_MSB - ST_COUNT_LSB + 1;

    typedef enum logic [1:0] {
        BANK_RAM,
        BANK_IO,
        BANK_NONE
    } bank_e;

    // Bank 0 is always RAM, even if the I/O bank is configured as 0.
    function automatic bank_e decode_bank(input logic [7:0] bank, input logic [7:0] io_bank);
        if (bank == 8'h00) begin
            return BANK_RAM;
        end
        if (bank == io_bank) begin
            return BANK_IO;
        end
        return BANK_NONE;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// mem_io_bridge_if: bus bundle between the core, the RAM and the TX consumer.
//   core_addr/core_wdata/core_we/core_rdata : core access port
//   ram_addr/ram_wdata/ram_we/ram_rdata     : RAM pass-through port
//   tx_data/tx_valid/tx_ready               : TX byte stream
// The slave modport is the bridge view; the master modport is the
// environment (core, RAM and consumer together).
interface mem_io_bridge_if;

    logic [23:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_we;
    logic [15:0] core_rdata;

    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output core_addr, core_wdata, core_we, ram_rdata, tx_ready,
        input  core_rdata, ram_addr, ram_wdata, ram_we, tx_data, tx_valid
    );

    modport slave (
        input  core_addr, core_wdata, core_we, ram_rdata, tx_ready,
        output core_rdata, ram_addr, ram_wdata, ram_we, tx_data, tx_valid
    );

endinterface

// File: rtl/mem_io_bridge_tx_fifo.sv
// tx_fifo: byte FIFO for the TX stream, no fall-through.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : push request and byte; dropped when full unless popping
//   pop, dout  : pop request (ignored when empty) and head byte
//   full, empty, count : occupancy, count spans 0..DEPTH
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [7:0]    mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot this edge.
    assign do_push = push && (!full || do_pop);

    // Pointers are log2(DEPTH) wide, so wrap-around is the natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes a 24-bit core bus into RAM pass-through (bank 0),
// an I/O register block (bank IO_BANK) and an unmapped region.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : core, RAM and TX stream signals (slave view)
//   gpio_out   : GPIO output register
//   gpio_in    : GPIO input pins, double-flop synchronised
// I/O registers: GPIO_OUT, GPIO_IN, TX_DATA (push to tx_fifo), STATUS
// (FIFO state + sticky overflow, W1C), TIMER_LO (live) / TIMER_HI (snapshot).
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  IO_BANK    = IO_BANK_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    mem_io_bridge_if.slave   bus,
    output logic [15:0]      gpio_out,
    input  logic [15:0]      gpio_in
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    bank_e              bank_sel;
    logic [15:0]        offset;
    logic               io_we;
    logic               io_rd;

    logic [31:0]        timer;
    logic [15:0]        snapshot;
    logic               overflow;
    logic [15:0]        gpio_s1;
    logic [15:0]        gpio_s2;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [7:0]         fifo_dout;

    logic               ovf_set;
    logic               ovf_clr;
    logic               snap_capture;
    logic [15:0]        status;

    assign bank_sel = decode_bank(bus.core_addr[23:16], IO_BANK);
    assign offset   = bus.core_addr[15:0];
    assign io_we    = (bank_sel == BANK_IO) && bus.core_we;
    assign io_rd    = (bank_sel == BANK_IO) && !bus.core_we;

    // RAM side is a straight pass-through, independent of reset.
    assign bus.ram_addr  = bus.core_addr[15:0];
    assign bus.ram_wdata = bus.core_wdata;
    assign bus.ram_we    = bus.core_we && (bank_sel == BANK_RAM);

    assign fifo_push    = io_we && (offset == OFF_TX_DATA);
    assign fifo_pop     = !fifo_empty && bus.tx_ready;
    assign ovf_set      = fifo_push && fifo_full && !fifo_pop;
    assign ovf_clr      = io_we && (offset == OFF_STATUS) && bus.core_wdata[ST_OVERFLOW];
    assign snap_capture = io_rd && (offset == OFF_TIMER_LO);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (bus.core_wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.tx_data  = fifo_dout;
    assign bus.tx_valid = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
            timer    <= '0;
            snapshot <= '0;
            overflow <= 1'b0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            timer   <= timer + 32'd1;
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            if (io_we && (offset == OFF_GPIO_OUT)) begin
                gpio_out <= bus.core_wdata;
            end
            // Reading TIMER_LO freezes the upper half so a following TIMER_HI
            // read is coherent with the low half just returned.
            if (snap_capture) begin
                snapshot <= timer[31:16];
            end
            // Set takes priority over a simultaneous W1C.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status                            = '0;
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_COUNT_MSB:ST_COUNT_LSB] = ST_COUNT_W'(fifo_count);
        status[ST_OVERFLOW]               = overflow;
    end

    always_comb begin
        bus.core_rdata = '0;
        case (bank_sel)
            BANK_RAM: bus.core_rdata = bus.ram_rdata;
            BANK_IO: begin
                case (offset)
                    OFF_GPIO_OUT: bus.core_rdata = gpio_out;
                    OFF_GPIO_IN:  bus.core_rdata = gpio_s2;
                    OFF_STATUS:   bus.core_rdata = status;
                    OFF_TIMER_LO: bus.core_rdata = timer[15:0];
                    OFF_TIMER_HI: bus.core_rdata = snapshot;
                    default:      bus.core_rdata = '0;
                endcase
            end
            default: bus.core_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: randomized, scoreboard-checked bench for mem_io_bridge.
// The reference model is a byte queue plus a handful of registers that follow
// the register map directly; reads push their expected value at issue time
// and a monitor on the falling edge pops and compares.
module tb_mem_io_bridge;

    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  IOB   = 8'hFF;

    localparam logic [23:0] A_GPIO_OUT = 24'hFF0000;
    localparam logic [23:0] A_GPIO_IN  = 24'hFF0001;
    localparam logic [23:0] A_TX       = 24'hFF0002;
    localparam logic [23:0] A_STATUS   = 24'hFF0003;
    localparam logic [23:0] A_TLO      = 24'hFF0004;
    localparam logic [23:0] A_THI      = 24'hFF0005;
    localparam logic [23:0] A_IDLE     = 24'h010000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;

    mem_io_bridge_if bus ();

    mem_io_bridge #(
        .FIFO_DEPTH (DEPTH),
        .IO_BANK    (IOB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0]  mq[$];
    logic        m_ovf;
    logic [15:0] m_gpio_out;
    logic [15:0] m_s1;
    logic [15:0] m_s2;
    logic [15:0] m_snap;
    logic [31:0] m_timer;

    // read scoreboard
    logic [15:0] rdq[$];
    string       rdn[$];
    logic        rd_req = 1'b0;
    logic [7:0]  seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        m_ovf      = 1'b0;
        m_gpio_out = '0;
        m_s1       = '0;
        m_s2       = '0;
        m_snap     = '0;
        m_timer    = '0;
    endfunction

    function automatic logic [15:0] model_read(input logic [23:0] a);
        logic [15:0] st;
        st = {8'h00, m_ovf, 5'(mq.size()), (mq.size() == 0), (mq.size() == DEPTH)};
        if (a[23:16] == 8'h00) return bus.ram_rdata;
        if (a[23:16] != IOB) return 16'h0000;
        case (a[15:0])
            16'd0:   return m_gpio_out;
            16'd1:   return m_s2;
            16'd3:   return st;
            16'd4:   return m_timer[15:0];
            16'd5:   return m_snap;
            default: return 16'h0000;
        endcase
    endfunction

    // Reference model advances on every rising edge from the driven inputs.
    initial begin
        logic        io;
        logic [15:0] off;
        logic        we;
        logic        pop;
        logic        push;
        logic        set;
        logic        clr;
        forever begin
            @(posedge clk);
            if (reset) begin
                model_clear();
            end else begin
                io   = (bus.core_addr[23:16] == IOB) && (bus.core_addr[23:16] != 8'h00);
                off  = bus.core_addr[15:0];
                we   = bus.core_we;
                pop  = (mq.size() != 0) && bus.tx_ready;
                push = io && we && (off == 16'd2);
                set  = push && (mq.size() == DEPTH) && !pop;
                clr  = io && we && (off == 16'd3) && bus.core_wdata[7];
                if (io && !we && (off == 16'd4)) m_snap = m_timer[31:16];
                if (io && we && (off == 16'd0)) m_gpio_out = bus.core_wdata;
                if (pop) void'(mq.pop_front());
                if (push && !set) mq.push_back(bus.core_wdata[7:0]);
                if (set) m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
                m_s2    = m_s1;
                m_s1    = gpio_in;
                m_timer = m_timer + 32'd1;
            end
        end
    end

    // Monitor: compares DUT outputs against the model on the falling edge.
    initial begin
        logic [15:0] exp;
        string       nm;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("tx_valid", 32'(bus.tx_valid), 32'(mq.size() != 0));
                if ((mq.size() != 0) && bus.tx_ready) begin
                    check("tx_data", 32'(bus.tx_data), 32'(mq[0]));
                    seen.push_back(bus.tx_data);
                end
                check("gpio_out", 32'(gpio_out), 32'(m_gpio_out));
                check("ram_addr", 32'(bus.ram_addr), 32'(bus.core_addr[15:0]));
                check("ram_wdata", 32'(bus.ram_wdata), 32'(bus.core_wdata));
                check("ram_we", 32'(bus.ram_we), 32'(bus.core_we && (bus.core_addr[23:16] == 8'h00)));
                if (rd_req) begin
                    if (rdq.size() == 0) begin
                        check("rd_queue_underflow", 32'd1, 32'd0);
                    end else begin
                        exp = rdq.pop_front();
                        nm  = rdn.pop_front();
                        check(nm, 32'(bus.core_rdata), 32'(exp));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic op_idle();
        bus.core_addr = A_IDLE;
        bus.core_we   = 1'b0;
        step();
    endtask

    task automatic op_wr(input logic [23:0] a, input logic [15:0] d);
        bus.core_addr  = a;
        bus.core_wdata = d;
        bus.core_we    = 1'b1;
        step();
    endtask

    task automatic op_rd(input logic [23:0] a, input logic [15:0] exp, input string nm);
        bus.core_addr = a;
        bus.core_we   = 1'b0;
        rdq.push_back(exp);
        rdn.push_back(nm);
        rd_req = 1'b1;
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [15:0] off;
        logic [7:0]  b;
        int unsigned sel;
        int unsigned guard;

        reset          = 1'b1;
        bus.core_addr  = A_IDLE;
        bus.core_wdata = '0;
        bus.core_we    = 1'b0;
        bus.ram_rdata  = 16'h1357;
        bus.tx_ready   = 1'b0;
        gpio_in        = '0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        op_rd(A_STATUS, 16'h0002, "reset_status");
        op_rd(A_GPIO_OUT, 16'h0000, "reset_gpio_out");
        op_rd(A_THI, 16'h0000, "reset_snapshot");

        // RAM pass-through and unmapped bank
        op_wr(24'h000010, 16'hBEEF);
        bus.ram_rdata = 16'h5A3C;
        op_rd(24'h000010, 16'h5A3C, "ram_read");
        op_wr(24'h120010, 16'h1111);
        op_rd(24'h120010, 16'h0000, "unmapped_read");

        // GPIO
        gpio_in = 16'h1234;
        op_wr(A_GPIO_OUT, 16'h00A5);
        op_rd(A_GPIO_OUT, 16'h00A5, "gpio_out_read");
        op_rd(A_GPIO_IN, 16'h1234, "gpio_in_sync");

        // FIFO fill and overflow
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) op_wr(A_TX, 16'(i));
        op_rd(A_STATUS, 16'h00A1, "status_full_ovf");
        op_rd(A_TX, 16'h0000, "tx_data_read_zero");
        seen.delete();
        bus.tx_ready = 1'b1;
        repeat (12) op_idle();
        check("drain_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < seen.size()) check("drain_order", 32'(seen[i]), 32'(i + 1));
        end

        // overflow clear
        op_wr(A_STATUS, 16'h0080);
        op_rd(A_STATUS, 16'h0002, "status_ovf_clear");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.tx_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
            sel = $urandom_range(0, 9);
            off = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            case (sel)
                0, 1, 2, 3: op_wr(A_TX, 16'($urandom));
                4: op_wr({IOB, off}, 16'($urandom));
                5: begin
                    a = {IOB, off};
                    op_rd(a, model_read(a), "rnd_io_read");
                end
                6: op_wr({8'h00, 16'($urandom)}, 16'($urandom));
                7: begin
                    bus.ram_rdata = 16'($urandom);
                    a = {8'h00, 16'($urandom)};
                    op_rd(a, model_read(a), "rnd_ram_read");
                end
                8: begin
                    b = 8'($urandom_range(1, 254));
                    a = {b, off};
                    if ($urandom_range(0, 1) == 0) op_wr(a, 16'($urandom));
                    else op_rd(a, model_read(a), "rnd_unmapped_read");
                end
                default: op_wr(A_STATUS, 16'($urandom));
            endcase
        end
        op_rd(A_STATUS, model_read(A_STATUS), "rnd_final_status");

        // reset with data queued
        bus.tx_ready = 1'b1;
        repeat (DEPTH + 2) op_idle();
        bus.tx_ready = 1'b0;
        op_wr(A_TX, 16'h0011);
        op_wr(A_TX, 16'h0022);
        op_wr(A_TX, 16'h0033);
        op_rd(A_STATUS, 16'h000C, "status_three_queued");
        bus.core_addr = A_IDLE;
        bus.core_we   = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("async_reset_gpio_out", 32'(gpio_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op_rd(A_STATUS, 16'h0002, "status_after_reset");

        // timer coherence across the 16-bit boundary
        guard = 0;
        while ((m_timer != 32'h0000FFFF) && (guard < 70000)) begin
            op_idle();
            guard++;
        end
        check("timer_wait_bound", 32'(m_timer == 32'h0000FFFF), 32'd1);
        op_rd(A_TLO, 16'hFFFF, "timer_lo_ffff");
        op_rd(A_THI, 16'h0000, "timer_hi_snapshot");
        op_rd(A_TLO, model_read(A_TLO), "timer_lo_after");
        op_rd(A_THI, 16'h0001, "timer_hi_next");
        op_idle();

        check("rd_queue_empty", 32'(rdq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
